// File: rtl/mdiv_ctrl_if.sv
// Bundle of decode, mult/div unit and register-file write-port signals for mdiv_ctrl.
// master = surrounding pipeline/unit/arbiter, slave = the controller.
interface mdiv_ctrl_if;
  logic        req_mult;
  logic        req_div;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [4:0]  rd;
  logic        md_start;
  logic        md_op;
  logic [31:0] md_A;
  logic [31:0] md_B;
  logic        md_ready;
  logic [31:0] md_result;
  logic        md_exception;
  logic        stall;
  logic        wb_req;
  logic        wb_grant;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  modport master (
    output req_mult, req_div, opA, opB, rd, md_ready, md_result, md_exception, wb_grant,
    input  md_start, md_op, md_A, md_B, stall, wb_req, wb_reg, wb_data
  );

  modport slave (
    input  req_mult, req_div, opA, opB, rd, md_ready, md_result, md_exception, wb_grant,
    output md_start, md_op, md_A, md_B, stall, wb_req, wb_reg, wb_data
  );
endinterface

// File: rtl/mdiv_ctrl.sv
// Sequencer between decode and a shared iterative mult/div unit: issues one
// operation, waits with a timeout, and writes the result or an exception code back.
//   state | meaning
//   IDLE  | no operation; accepts req_mult/req_div
//   ISSUE | pulse md_start, clear wait counter
//   WAIT  | count cycles until md_ready or timeout
//   WB    | hold wb_req with stable reg/data until granted
module mdiv_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int RSTATUS = 30
) (
  input logic       clock,
  input logic       reset,
  mdiv_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  localparam logic [5:0]  CNT_LAST    = 6'(TIMEOUT - 1);
  localparam logic [4:0]  RSTATUS_REG = 5'(RSTATUS);
  localparam logic [31:0] EXC_MULT    = 32'd4;
  localparam logic [31:0] EXC_DIV     = 32'd5;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic accept;
  logic [31:0] exc_data;

  // Requests seen while reset is low must not stall or be accepted.
  assign accept   = reset && (state_q == S_IDLE) && (bus.req_mult || bus.req_div);
  assign exc_data = op_q ? EXC_DIV : EXC_MULT;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = !bus.req_mult;
          a_d  = bus.opA;
          b_d  = bus.opB;
          rd_d = bus.rd;
          if (!bus.req_mult && (bus.opB == 32'd0)) begin
            state_d   = S_WB;
            wb_reg_d  = RSTATUS_REG;
            wb_data_d = EXC_DIV;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = 6'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 6'd1;
        // A result landing on the timeout cycle still wins.
        if (bus.md_ready) begin
          if (bus.md_exception) begin
            state_d   = S_WB;
            wb_reg_d  = RSTATUS_REG;
            wb_data_d = exc_data;
          end else if (rd_q == 5'd0) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_WB;
            wb_reg_d  = rd_q;
            wb_data_d = bus.md_result;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_WB;
          wb_reg_d  = RSTATUS_REG;
          wb_data_d = exc_data;
        end
      end
      S_WB: begin
        if (bus.wb_grant) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      op_q      <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      rd_q      <= 5'd0;
      wb_reg_q  <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.stall    = (state_q != S_IDLE) || accept;
  assign bus.md_start = (state_q == S_ISSUE);
  assign bus.md_op    = op_q;
  assign bus.md_A     = a_q;
  assign bus.md_B     = b_q;
  assign bus.wb_req   = (state_q == S_WB);
  assign bus.wb_reg   = wb_reg_q;
  assign bus.wb_data  = wb_data_q;

endmodule

// File: tb/tb_mdiv_ctrl.sv
// Self-checking bench for mdiv_ctrl: directed and random transactions compared
// against a transaction-level model of the controller's observable behaviour.
module tb_mdiv_ctrl;

  localparam int TIMEOUT = 40;
  localparam int RSTATUS = 30;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  mdiv_ctrl_if bus ();

  mdiv_ctrl #(.TIMEOUT(TIMEOUT), .RSTATUS(RSTATUS)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          starts;
    bit          dowb;
    int          stall;
    int          wbcyc;
    int          nwb;
    logic        op;
    logic [4:0]  wbreg;
    logic [31:0] wbdata;
  } pred_t;

  typedef struct {
    logic        rm;
    logic        rdv;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          ready_at;
    logic        exc;
    logic [31:0] res;
    int          gdly;
    bit          spur;
  } txn_t;

  typedef struct {
    int          stall;
    int          nstart;
    int          startcyc;
    int          wbcyc;
    int          nwb;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wbreg;
    logic [31:0] wbdata;
    bit          stable;
    bit          hung;
  } obs_t;

  // ready_at: WAIT cycle (1-based) carrying md_ready, 0 = unit never answers.
  function automatic pred_t model(input txn_t t);
    pred_t p;
    bit    mult;
    bit    div0;
    bit    e;
    int    waitn;
    mult     = t.rm;
    div0     = !mult && (t.b == 32'd0);
    waitn    = (t.ready_at == 0) ? TIMEOUT : t.ready_at;
    e        = div0 || (t.ready_at == 0) || t.exc;
    p.starts = !div0;
    p.dowb   = e || (t.rd != 5'd0);
    p.op     = !mult;
    p.wbreg  = e ? 5'(RSTATUS) : t.rd;
    p.wbdata = e ? (mult ? 32'd4 : 32'd5) : t.res;
    p.wbcyc  = p.starts ? 2 + waitn : 1;
    p.nwb    = p.dowb ? t.gdly + 1 : 0;
    p.stall  = 1 + (p.starts ? 1 + waitn : 0) + p.nwb;
    return p;
  endfunction

  task automatic drive_txn(input txn_t t, input int busy_until, output obs_t o);
    bit done;
    o.stall = 0; o.nstart = 0; o.startcyc = -1; o.wbcyc = -1; o.nwb = 0;
    o.op = 1'b0; o.a = '0; o.b = '0; o.wbreg = '0; o.wbdata = '0;
    o.stable = 1'b1; o.hung = 1'b0;
    done = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      #1;
      if (bus.md_start) begin
        o.nstart++;
        if (o.startcyc < 0) begin
          o.startcyc = cyc; o.op = bus.md_op; o.a = bus.md_A; o.b = bus.md_B;
        end
      end
      if (bus.wb_req) begin
        if (o.nwb == 0) begin
          o.wbcyc = cyc; o.wbreg = bus.wb_reg; o.wbdata = bus.wb_data;
        end else if (bus.wb_reg !== o.wbreg || bus.wb_data !== o.wbdata) begin
          o.stable = 1'b0;
        end
        o.nwb++;
      end
      bus.req_mult = 1'b0;
      bus.req_div  = 1'b0;
      if (cyc == 0) begin
        bus.req_mult = t.rm; bus.req_div = t.rdv;
        bus.opA = t.a; bus.opB = t.b; bus.rd = t.rd;
      end else if (t.spur && cyc < busy_until) begin
        bus.req_mult = 1'($urandom); bus.req_div = 1'($urandom);
        bus.opA = $urandom; bus.opB = $urandom; bus.rd = 5'($urandom);
      end
      if (o.startcyc >= 0 && t.ready_at > 0 && cyc == o.startcyc + t.ready_at) begin
        bus.md_ready = 1'b1; bus.md_exception = t.exc; bus.md_result = t.res;
      end else if (t.spur && (cyc == o.startcyc || bus.wb_req)) begin
        bus.md_ready = 1'b1; bus.md_exception = 1'b1; bus.md_result = $urandom;
      end else begin
        bus.md_ready = 1'b0; bus.md_exception = 1'b0; bus.md_result = $urandom;
      end
      bus.wb_grant = bus.wb_req && (o.nwb - 1 == t.gdly);
      #1;
      if (bus.stall) o.stall++;
      else if (cyc > 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) o.hung = 1'b1;
    bus.md_ready = 1'b0;
    bus.wb_grant = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_mult = 1'b1; bus.req_div = 1'b0;
    bus.opA = 32'h1111; bus.opB = 32'h2222; bus.rd = 5'd3;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (bus.stall !== 1'b0 || bus.md_start !== 1'b0 || bus.wb_req !== 1'b0 || bus.md_op !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctl stall=%b md_start=%b wb_req=%b md_op=%b, want all 0",
               bus.stall, bus.md_start, bus.wb_req, bus.md_op);
    end
    tests_run++;
    if (bus.md_A !== 32'd0 || bus.md_B !== 32'd0 || bus.wb_reg !== 5'd0 || bus.wb_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_data md_A=%h md_B=%h wb_reg=%0d wb_data=%h, want all 0",
               bus.md_A, bus.md_B, bus.wb_reg, bus.wb_data);
    end
    bus.req_mult = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (bus.stall !== 1'b0 || bus.md_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_discard stall=%b md_start=%b, want 0 0", bus.stall, bus.md_start);
    end
  endtask

  task automatic test_directed();
    txn_t  tv[8];
    pred_t p;
    obs_t  o;
    tv[0] = '{1'b1, 1'b0, 32'd7,   32'd6, 5'd5,  3,  1'b0, 32'd42,      0, 1'b0};
    tv[1] = '{1'b0, 1'b1, 32'd11,  32'd0, 5'd9,  0,  1'b0, 32'd0,       0, 1'b0};
    tv[2] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'd3, 5'd8, 2, 1'b1, 32'hDEAD, 4, 1'b0};
    tv[3] = '{1'b0, 1'b1, 32'd100, 32'd7, 5'd3,  0,  1'b0, 32'd0,       0, 1'b0};
    tv[4] = '{1'b1, 1'b1, 32'd9,   32'd0, 5'd0,  5,  1'b0, 32'd123,     0, 1'b0};
    tv[5] = '{1'b0, 1'b1, 32'd50,  32'd2, 5'd7,  TIMEOUT, 1'b0, 32'h1234, 1, 1'b0};
    tv[6] = '{1'b0, 1'b1, 32'd1,   32'd0, 5'd0,  0,  1'b0, 32'd0,       2, 1'b0};
    tv[7] = '{1'b1, 1'b0, 32'd13,  32'd3, 5'd12, 4,  1'b0, 32'd39,      2, 1'b1};
    for (int i = 0; i < 8; i++) begin
      p = model(tv[i]);
      drive_txn(tv[i], p.stall, o);
      tests_run++;
      if (o.hung || o.stall != p.stall) begin
        tests_failed++;
        $display("FAIL dir%0d_stall got %0d (hung=%b) want %0d", i, o.stall, o.hung, p.stall);
      end
      tests_run++;
      if (o.nstart != (p.starts ? 1 : 0)) begin
        tests_failed++;
        $display("FAIL dir%0d_md_start got %0d pulses want %0d", i, o.nstart, p.starts ? 1 : 0);
      end
      if (p.starts) begin
        tests_run++;
        if (o.op !== p.op || o.a !== tv[i].a || o.b !== tv[i].b) begin
          tests_failed++;
          $display("FAIL dir%0d_operands got op=%b A=%h B=%h want op=%b A=%h B=%h",
                   i, o.op, o.a, o.b, p.op, tv[i].a, tv[i].b);
        end
      end
      tests_run++;
      if (o.nwb != p.nwb || (p.dowb && o.wbcyc != p.wbcyc)) begin
        tests_failed++;
        $display("FAIL dir%0d_wb_timing got %0d req cycles from cycle %0d want %0d from %0d",
                 i, o.nwb, o.wbcyc, p.nwb, p.wbcyc);
      end
      if (p.dowb) begin
        tests_run++;
        if (o.wbreg !== p.wbreg || o.wbdata !== p.wbdata || !o.stable) begin
          tests_failed++;
          $display("FAIL dir%0d_wb_value got reg=%0d data=%h stable=%b want reg=%0d data=%h stable=1",
                   i, o.wbreg, o.wbdata, o.stable, p.wbreg, p.wbdata);
        end
      end
    end
  endtask

  task automatic test_random();
    txn_t  t;
    pred_t p;
    obs_t  o;
    for (int i = 0; i < 30; i++) begin
      t.rm   = 1'($urandom);
      t.rdv  = t.rm ? 1'($urandom) : 1'b1;
      t.a    = $urandom;
      t.b    = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      t.rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      case ($urandom_range(0, 5))
        0:       t.ready_at = 0;
        1:       t.ready_at = TIMEOUT;
        default: t.ready_at = $urandom_range(1, 12);
      endcase
      t.exc  = ($urandom_range(0, 3) == 0);
      t.res  = $urandom;
      t.gdly = $urandom_range(0, 3);
      t.spur = 1'($urandom);
      p = model(t);
      drive_txn(t, p.stall, o);
      tests_run++;
      if (o.hung || o.stall != p.stall || o.nstart != (p.starts ? 1 : 0)) begin
        tests_failed++;
        $display("FAIL rnd%0d_seq got stall=%0d starts=%0d hung=%b want stall=%0d starts=%0d",
                 i, o.stall, o.nstart, o.hung, p.stall, p.starts ? 1 : 0);
      end
      if (p.starts) begin
        tests_run++;
        if (o.op !== p.op || o.a !== t.a || o.b !== t.b) begin
          tests_failed++;
          $display("FAIL rnd%0d_operands got op=%b A=%h B=%h want op=%b A=%h B=%h",
                   i, o.op, o.a, o.b, p.op, t.a, t.b);
        end
      end
      tests_run++;
      if (o.nwb != p.nwb || (p.dowb && (o.wbcyc != p.wbcyc || o.wbreg !== p.wbreg ||
                                        o.wbdata !== p.wbdata || !o.stable))) begin
        tests_failed++;
        $display("FAIL rnd%0d_wb got n=%0d cyc=%0d reg=%0d data=%h stable=%b want n=%0d cyc=%0d reg=%0d data=%h",
                 i, o.nwb, o.wbcyc, o.wbreg, o.wbdata, o.stable, p.nwb, p.wbcyc, p.wbreg, p.wbdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req_mult = 1'b0; bus.req_div = 1'b1;
    bus.opA = 32'd99; bus.opB = 32'd3; bus.rd = 5'd4;
    @(negedge clk);
    bus.req_div = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus.stall !== 1'b0 || bus.md_start !== 1'b0 || bus.wb_req !== 1'b0 || bus.md_op !== 1'b0 ||
        bus.md_A !== 32'd0 || bus.md_B !== 32'd0 || bus.wb_reg !== 5'd0 || bus.wb_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL midreset_outputs stall=%b start=%b wb_req=%b op=%b A=%h B=%h reg=%0d data=%h, want all 0",
               bus.stall, bus.md_start, bus.wb_req, bus.md_op, bus.md_A, bus.md_B, bus.wb_reg, bus.wb_data);
    end
    bus.md_ready = 1'b1; bus.md_exception = 1'b0; bus.md_result = 32'd77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (bus.stall !== 1'b0 || bus.wb_req !== 1'b0 || bus.md_start !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset_late_ready%0d stall=%b wb_req=%b start=%b, want 0 0 0",
                 i, bus.stall, bus.wb_req, bus.md_start);
      end
    end
    bus.md_ready = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    bus.req_mult = 1'b0; bus.req_div = 1'b0;
    bus.opA = '0; bus.opB = '0; bus.rd = '0;
    bus.md_ready = 1'b0; bus.md_result = '0; bus.md_exception = 1'b0;
    bus.wb_grant = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
